// File: rtl/song_pkg.sv
// Shared types and default constants for the song player and its tone generator.
package song_pkg;

  localparam int unsigned NOTE_W   = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned SONG_LEN = 26;
  localparam int unsigned CLK_HZ   = 12_000_000;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts one full note period and drives the first half high.
module tone_gen #(
  parameter int unsigned NOTE_W = song_pkg::NOTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NOTE_W-1:0] period,
  output logic              wave
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              audible_c;

  // Periods of 0 and 1 are rests: counter parked at 0, output silent.
  assign audible_c = period >= NOTE_W'(2);

  always_comb begin
    cnt_d = '0;
    if (enable && audible_c && (cnt_q != period - NOTE_W'(1))) begin
      cnt_d = cnt_q + NOTE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Odd periods give floor(N/2) high cycles and ceil(N/2) low cycles.
  assign wave = enable && audible_c && (cnt_q < (period >> 1));

endmodule

// File: rtl/song_player.sv
// Steps the song ROM, plays each note for a fixed duration followed by a silent gap.
module song_player #(
  parameter int unsigned NOTE_CYCLES = 3_000_000,
  parameter int unsigned GAP_CYCLES  = 600_000,
  parameter int unsigned SONG_LEN    = song_pkg::SONG_LEN,
  parameter int unsigned ADDR_W      = song_pkg::ADDR_W,
  parameter int unsigned NOTE_W      = song_pkg::NOTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NOTE_W-1:0] note,
  output logic [ADDR_W-1:0] address,
  output logic              speaker,
  output logic              busy,
  output logic              done
);

  import song_pkg::*;

  localparam int unsigned DUR_MAX0  = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned DUR_MAX   = (DUR_MAX0 > 1) ? DUR_MAX0 : 1;
  localparam int unsigned DUR_W     = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int unsigned NOTE_LAST = NOTE_CYCLES - 1;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HAS_GAP   = GAP_CYCLES > 0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              advance_c;

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    note_d    = note_q;
    dur_d     = dur_q;
    advance_c = 1'b0;

    // stop outranks start and every terminal count.
    if (stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      address_d = '0;
      dur_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d   = FETCH;
            address_d = '0;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          note_d  = note;
          dur_d   = '0;
          state_d = PLAY;
        end
        PLAY: begin
          if (dur_q == DUR_W'(NOTE_LAST)) begin
            dur_d = '0;
            if (HAS_GAP) state_d = GAP;
            else         advance_c = 1'b1;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        GAP: begin
          if (dur_q == DUR_W'(GAP_LAST)) begin
            dur_d     = '0;
            advance_c = 1'b1;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Next-step decision after a note (and its gap) completes.
    if (advance_c) begin
      if (address_q == ADDR_W'(SONG_LEN - 1)) begin
        state_d = DONE;
      end else begin
        address_d = address_q + ADDR_W'(1);
        state_d   = FETCH;
      end
    end

    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      address_q <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  tone_gen #(
    .NOTE_W (NOTE_W)
  ) u_tone_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q == PLAY),
    .period (note_q),
    .wave   (speaker)
  );

  assign address = address_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: one gapped instance and one gap-less instance share a 3-note ROM.
module tb_song_player;

  localparam int unsigned NC = 20;
  localparam int unsigned GC = 4;
  localparam int unsigned SL = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, start2, stop2;
  logic [NW-1:0] note, note2;
  logic [AW-1:0] address, address2;
  logic          speaker, busy, done;
  logic          speaker2, busy2, done2;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] tr_addr [0:127];
  logic          tr_spk  [0:127];
  logic          tr_busy [0:127];
  logic          tr_done [0:127];

  // Hand-derived speaker slots per note, MSB = first cycle of the note (FETCH).
  logic [25:0] exp_spk [0:2];
  int          exp_hi  [0:2];

  always #5 clk = ~clk;

  function automatic logic [NW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      5'd0:    return 16'd8;
      5'd1:    return 16'd0;
      5'd2:    return 16'd5;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    note  <= rom_f(address);
    note2 <= rom_f(address2);
  end

  song_player #(
    .NOTE_CYCLES (NC), .GAP_CYCLES (GC), .SONG_LEN (SL), .ADDR_W (AW), .NOTE_W (NW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .note (note),
    .address (address), .speaker (speaker), .busy (busy), .done (done)
  );

  song_player #(
    .NOTE_CYCLES (NC), .GAP_CYCLES (0), .SONG_LEN (SL), .ADDR_W (AW), .NOTE_W (NW)
  ) dut_nogap (
    .clk (clk), .rst_n (rst_n), .start (start2), .stop (stop2), .note (note2),
    .address (address2), .speaker (speaker2), .busy (busy2), .done (done2)
  );

  task automatic start_pulse(input bit on2);
    if (on2) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic capture(input int n, input int kick_k, input bit on2);
    for (int k = 0; k < n; k++) begin
      tr_addr[k] = on2 ? address2 : address;
      tr_spk[k]  = on2 ? speaker2 : speaker;
      tr_busy[k] = on2 ? busy2    : busy;
      tr_done[k] = on2 ? done2    : done;
      start = (k == kick_k);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input int per, input string tag);
    logic [AW-1:0] ea;
    logic [25:0]   vec;
    int            last;
    last = SL * per;
    for (int k = 0; k <= last + 1; k++) begin
      ea = (k < last) ? AW'(k / per) : AW'(SL - 1);
      total++;
      if (tr_addr[k] !== ea) begin
        bad++;
        $display("FAIL %s_addr k=%0d got=%0d exp=%0d", tag, k, tr_addr[k], ea);
      end
      total++;
      if (tr_busy[k] !== (k <= last)) begin
        bad++;
        $display("FAIL %s_busy k=%0d got=%b exp=%b", tag, k, tr_busy[k], (k <= last));
      end
      total++;
      if (tr_done[k] !== (k == last)) begin
        bad++;
        $display("FAIL %s_done k=%0d got=%b exp=%b", tag, k, tr_done[k], (k == last));
      end
    end
    for (int j = 0; j < int'(SL); j++) begin
      vec = '0;
      for (int o = 0; o < per; o++) vec[25-o] = tr_spk[j*per + o];
      total++;
      if (vec !== exp_spk[j]) begin
        bad++;
        $display("FAIL %s_spk note=%0d got=%b exp=%b", tag, j, vec, exp_spk[j]);
      end
      total++;
      if ($countones(vec) != exp_hi[j]) begin
        bad++;
        $display("FAIL %s_high note=%0d got=%0d exp=%0d", tag, j, $countones(vec), exp_hi[j]);
      end
    end
  endtask

  task automatic check_idle(input string tag, input logic [AW-1:0] ea);
    total++;
    if (address !== ea) begin bad++; $display("FAIL %s_addr got=%0d exp=%0d", tag, address, ea); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s_done got=%b exp=0", tag, done); end
    total++;
    if (speaker !== 1'b0) begin bad++; $display("FAIL %s_spk got=%b exp=0", tag, speaker); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst", 5'd0);
    total++;
    if (address2 !== 5'd0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL rst2 got addr=%0d busy=%b exp addr=0 busy=0", address2, busy2);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rst_rel", 5'd0);
  endtask

  task automatic test_playback;
    start_pulse(1'b0);
    capture(SL*26 + 4, -1, 1'b0);
    check_run(26, "play");
  endtask

  task automatic test_stop;
    int seen_busy, seen_done;
    start_pulse(1'b0);
    repeat (38) @(negedge clk);
    total++;
    if (address !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_pre got addr=%0d busy=%b exp addr=1 busy=1", address, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("stop", 5'd0);
    seen_busy = 0;
    seen_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) seen_busy++;
      if (done) seen_done++;
      @(negedge clk);
    end
    total++;
    if (seen_busy != 0 || seen_done != 0) begin
      bad++;
      $display("FAIL stop_quiet got busy_cycles=%0d done_cycles=%0d exp 0 and 0", seen_busy, seen_done);
    end
    start_pulse(1'b0);
    capture(SL*26 + 4, -1, 1'b0);
    check_run(26, "replay");
  endtask

  task automatic test_ignored_start;
    start_pulse(1'b0);
    capture(SL*26 + 4, 30, 1'b0);
    check_run(26, "kick");
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle("ss_idle", 5'(SL - 1));
      @(negedge clk);
    end
  endtask

  task automatic test_reset_gap;
    start_pulse(1'b0);
    repeat (49) @(negedge clk);
    total++;
    if (address !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL gap_pre got addr=%0d busy=%b exp addr=1 busy=1", address, busy);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst", 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_gap;
    start_pulse(1'b1);
    capture(SL*22 + 4, -1, 1'b1);
    check_run(22, "nogap");
  endtask

  initial begin
    exp_spk[0] = 26'b00_11110000111100001111_0000;
    exp_spk[1] = 26'b00_00000000000000000000_0000;
    exp_spk[2] = 26'b00_11000110001100011000_0000;
    exp_hi[0]  = 12;
    exp_hi[1]  = 0;
    exp_hi[2]  = 8;

    test_reset();
    test_playback();
    test_stop();
    test_ignored_start();
    test_reset_gap();
    test_no_gap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Sequencer and tone generator directly downstream of the song ROM.
- Steps the ROM address through the song and captures each returned 16-bit period word, which is a full square-wave period in clock cycles.
- Plays each note for a fixed duration, then inserts a silent gap, and drives a 1-bit speaker output.
- Single clock domain; started and aborted by the top-level button logic.

Parameters:
NOTE_CYCLES, 3_000_000, clock cycles each note sounds (250 ms at 12 MHz); must be >= 1
GAP_CYCLES, 600_000, silent clock cycles after each note; 0 means no gap
SONG_LEN, 26, number of ROM entries played (addresses 0..SONG_LEN-1); must be >= 1 and <= 2**ADDR_W
ADDR_W, 5, ROM address width
NOTE_W, 16, ROM note word width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins playback from address 0 when idle
stop  in  1  synchronous abort; returns to IDLE, silences speaker
note  in  NOTE_W  ROM data; valid one clock after address is sampled by the ROM
address  out  ADDR_W  ROM address, registered
speaker  out  1  square-wave audio output
busy  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive
done  out  1  one-cycle pulse when the last note's gap completes

Behaviour:
- Reset state (async, rst_n=0): IDLE, address=0, note_q=0, duration counter=0, tone counter=0, speaker=0, busy=0, done=0.
- FSM states and transitions:
  - IDLE: start=1 -> FETCH, address=0. start is ignored in every other state.
  - FETCH: one cycle; ROM samples address -> LOAD.
  - LOAD: one cycle; note_q <= note; tone counter and duration counter cleared -> PLAY.
  - PLAY: lasts exactly NOTE_CYCLES cycles. Duration counter counts 0..NOTE_CYCLES-1. At terminal count: -> GAP if GAP_CYCLES>0, else to the next-step decision.
  - GAP: lasts exactly GAP_CYCLES cycles, speaker=0. At terminal count: next-step decision.
  - Next-step decision: if address==SONG_LEN-1 -> DONE; else address <= address+1 and -> FETCH.
  - DONE: one cycle, done=1 -> IDLE. address holds its last value.
- Per-note cost is 2+NOTE_CYCLES+GAP_CYCLES cycles. done rises SONG_LEN*(2+NOTE_CYCLES+GAP_CYCLES) cycles after busy rises.
- Tone counter:
  - Runs only in PLAY, counts 0..note_q-1, then wraps to 0.
  - speaker = (state==PLAY) && (note_q>=2) && (tone counter < note_q>>1), decoded from registered state and counter only.
  - Odd note_q gives floor(N/2) high cycles and ceil(N/2) low cycles.
- Rest and degenerate notes: note_q of 0 or 1 means rest. speaker stays 0, the tone counter is held at 0, and the full duration is still consumed.
- stop: when stop=1 in any non-IDLE state, the next state is IDLE. address=0, speaker=0, busy=0, no done pulse. stop has priority over start and over all terminal counts.
- Simultaneous start and stop in IDLE: stop wins and the block stays in IDLE.
- Reset mid-playback: immediate return to the reset state. The ROM is not reset; its stale output is never used because LOAD always follows FETCH.
- busy = state != IDLE.
- Width rules:
  - Duration counter width is clog2(max(NOTE_CYCLES, GAP_CYCLES, 1)), shared between PLAY and GAP.
  - Tone counter is NOTE_W bits.
  - No arithmetic overflow is possible within these widths.

Decomposition:
- Shared package song_pkg:
  - state enum: IDLE, FETCH, LOAD, PLAY, GAP, DONE
  - default constants: NOTE_W=16, ADDR_W=5, SONG_LEN=26, CLK_HZ=12_000_000
  - REST_NOTE=0
- Sub-module tone_gen:
  - inputs: clk, rst_n, enable, period[NOTE_W]
  - output: wave
  - contains the tone counter and the speaker decode
  - enable=0 clears the counter and forces wave=0
- The top-level song_player holds the FSM, the address register and the duration counter.

Test Plan:
- Common setup for all scenarios: NOTE_CYCLES=20, GAP_CYCLES=4, SONG_LEN=3, and a bench ROM model with one-cycle registered latency returning notes {8, 0, 5}.
1. Reset, then pulse start -> busy rises next cycle; address 0, 1, 2 each held 26 cycles; done pulses exactly 78 cycles after busy rises; busy falls the cycle after done.
2. Note 8 -> in its 20 PLAY cycles speaker reads 1111000011110000 1111; 12 high cycles total; 0 during the 4 gap cycles.
3. Note 0 (rest) and note 5 (odd) -> note 0 gives speaker=0 for 20 cycles; note 5 gives pattern 11000 repeated 4 times, 8 high cycles.
4. Pulse stop at PLAY cycle 10 of address 1 -> next cycle IDLE, speaker=0, busy=0, address=0, no done pulse. A new start then replays from address 0.
5. Pulse start while busy, and start together with stop in IDLE -> both ignored; no restart, address sequence unchanged.
6. Drop rst_n asynchronously mid-GAP -> all outputs at reset values before the next clk edge. GAP_CYCLES=0 rerun: each note costs 22 cycles and done pulses 66 cycles after busy rises.
